// File: rtl/mc_path_gen.sv
// mc_path_gen: Monte Carlo path-sample producer.
// Generates PATH_NUM saturating random-walk paths of STEPS samples each,
// one sample per cycle, from start price S0, driven by a 16-bit Fibonacci
// LFSR (taps 16,14,13,11). The strike is latched and held on K_out.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         one-cycle run request (honoured only in IDLE)
//   S0, K_in      start price and strike, latched on accepted start
//   hold          downstream stall, freezes generation
//   path_out      current 12-bit sample
//   path_valid    path_out valid this cycle
//   path_last     final sample of a path
//   K_out         latched strike
//   busy          accepted start until done
//   done          one-cycle pulse after the final sample
//
// Optional feature (macro MC_PATH_GEN_ANTITHETIC_EN): odd paths replay the
// LFSR state of their even partner path with negated random deltas.
module mc_path_gen #(
    parameter int unsigned        STEPS     = 16,
    parameter int unsigned        PATH_NUM  = 1024,
    parameter logic [15:0]        LFSR_SEED = 16'hACE1,
    parameter int unsigned        VOL_SHIFT = 4,
    parameter logic signed [11:0] DRIFT     = 12'sd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] S0,
    input  logic [11:0] K_in,
    input  logic        hold,
    output logic [11:0] path_out,
    output logic        path_valid,
    output logic        path_last,
    output logic [11:0] K_out,
    output logic        busy,
    output logic        done
);

    localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned PATH_W = (PATH_NUM > 1) ? $clog2(PATH_NUM) : 1;
    localparam logic signed [13:0] DRIFT_X = {{2{DRIFT[11]}}, DRIFT};

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t              state;
    logic [11:0]         s_q;
    logic [11:0]         s0_q;
    logic [15:0]         lfsr;
    logic [STEP_W-1:0]   step_cnt;
    logic [PATH_W-1:0]   path_cnt;
`ifdef MC_PATH_GEN_ANTITHETIC_EN
    logic [15:0]         save_q;
`endif

    logic signed [13:0]  rnd_c;
    logic signed [13:0]  delta_c;
    logic signed [13:0]  sum_c;
    logic [11:0]         s_next_c;
    logic [15:0]         lfsr_adv_c;
    logic                last_step_c;
    logic                last_path_c;
    logic                neg_c;

    // Next sample: scaled random byte plus drift, saturated to 12 bits
    always_comb begin
`ifdef MC_PATH_GEN_ANTITHETIC_EN
        neg_c = path_cnt[0];
`else
        neg_c = 1'b0;
`endif
        rnd_c       = $signed({{6{lfsr[7]}}, lfsr[7:0]}) >>> VOL_SHIFT;
        delta_c     = (neg_c ? -rnd_c : rnd_c) + DRIFT_X;
        sum_c       = $signed({2'b00, s_q}) + delta_c;
        if (sum_c < 14'sd0) begin
            s_next_c = 12'd0;
        end else if (sum_c > 14'sd4095) begin
            s_next_c = 12'd4095;
        end else begin
            s_next_c = sum_c[11:0];
        end
        lfsr_adv_c  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        last_step_c = (step_cnt == STEP_W'(STEPS - 1));
        last_path_c = (path_cnt == PATH_W'(PATH_NUM - 1));
    end

    // Control FSM and all registered state/outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            s_q        <= 12'd0;
            s0_q       <= 12'd0;
            lfsr       <= LFSR_SEED;
            step_cnt   <= '0;
            path_cnt   <= '0;
`ifdef MC_PATH_GEN_ANTITHETIC_EN
            save_q     <= LFSR_SEED;
`endif
            path_out   <= 12'd0;
            path_valid <= 1'b0;
            path_last  <= 1'b0;
            K_out      <= 12'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            path_valid <= 1'b0;
            path_last  <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        s0_q  <= S0;
                        K_out <= K_in;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    s_q      <= s0_q;
                    step_cnt <= '0;
                    path_cnt <= '0;
`ifdef MC_PATH_GEN_ANTITHETIC_EN
                    save_q   <= lfsr;
`endif
                    state    <= RUN;
                end
                RUN: begin
                    if (!hold) begin
                        path_out   <= s_next_c;
                        path_valid <= 1'b1;
                        path_last  <= last_step_c;
                        if (last_step_c) begin
                            step_cnt <= '0;
                            s_q      <= s0_q;
                            path_cnt <= path_cnt + PATH_W'(1);
`ifdef MC_PATH_GEN_ANTITHETIC_EN
                            // Even path ends: rewind so the odd partner replays it.
                            // Odd path ends: carry on and mark the next pair's start.
                            if (!path_cnt[0]) begin
                                lfsr <= save_q;
                            end else begin
                                lfsr   <= lfsr_adv_c;
                                save_q <= lfsr_adv_c;
                            end
`else
                            lfsr     <= lfsr_adv_c;
`endif
                            if (last_path_c) begin
                                state <= DONE;
                            end
                        end else begin
                            step_cnt <= step_cnt + STEP_W'(1);
                            s_q      <= s_next_c;
                            lfsr     <= lfsr_adv_c;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
